ahb_sram_responder: RTL and testbench

AHB_SRAM_RESPONDER -- requirements
Module: ahb_sram_responder

---
 rtl/ahb_sram_responder.sv | 137 +++++++++++++
 tb/tb_ahb_sram_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM slave: single-port word memory with byte-lane writes, optional
// wait states, and a two-cycle ERROR response for out-of-range or illegal transfers.
module ahb_sram_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0]            state, state_nxt;
  logic [3:0]            wait_cnt, wait_cnt_nxt;
  logic [IDX_W-1:0]      idx_q;
  logic [1:0]            lane_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic [3:0]            byte_en;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic can_accept, accept, addr_hi_nz, size_bad, misaligned, illegal;
  logic unused_inputs;

  assign unused_inputs = ^{hburst, hprot, hmastlock};

  // A new address phase can only land in a cycle where this slave is ready.
  assign can_accept = (state == S_IDLE) || (state == S_LAST) || (state == S_ERR2);
  assign accept     = can_accept && hselx && hready && htrans[1];

  generate
    if (ADDR_WIDTH > IDX_W + 2) begin : g_addr_hi
      assign addr_hi_nz = |haddr[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_addr_hi
      assign addr_hi_nz = 1'b0;
    end
  endgenerate

  assign size_bad   = (hsize > 3'b010);
  assign misaligned = ((hsize == 3'b001) && haddr[0]) ||
                      ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
  assign illegal    = addr_hi_nz || size_bad || misaligned;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = S_LAST;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (illegal)               state_nxt = S_ERR1;
          else if (WAIT_STATES == 0) state_nxt = S_LAST;
          else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      lane_q   <= 2'b00;
      size_q   <= 3'b000;
      write_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        idx_q   <= haddr[IDX_W+1:2];
        lane_q  <= haddr[1:0];
        size_q  <= hsize;
        write_q <= hwrite;
      end
    end
  end

  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      3'b000:  byte_en[lane_q] = 1'b1;
      3'b001:  byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; contents survive hresetn.
  always_ff @(posedge hclk) begin
    if ((state == S_LAST) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hreadyout = !((state == S_WAIT) || (state == S_ERR1));
  assign hresp     = ((state == S_ERR1) || (state == S_ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign hrdata    = ((state == S_LAST) && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Directed bench for ahb_sram_responder: one instance with no wait states and
// one with two, sharing the address/data bus but selected individually.
module tb_ahb_sram_responder;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        ro0, ro2;
  logic [1:0]  rsp0, rsp2;
  logic [31:0] rd0, rd2;

  int n_vec = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  ahb_sram_responder #(.WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata), .hready(ro0), .hreadyout(ro0), .hresp(rsp0), .hrdata(rd0)
  );

  ahb_sram_responder #(.WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hsel2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata), .hready(ro2), .hreadyout(ro2), .hresp(rsp2), .hrdata(rd2)
  );

  // Single non-pipelined transfer. Entered and left at 1 time unit after a rising edge.
  // stalls counts data-phase cycles with hreadyout=0 (-1 if the transfer never completes).
  task automatic do_xfer(input logic use2, input logic [31:0] addr, input logic wr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic [1:0] resp, output int stalls,
                         output logic [1:0] first_resp, output logic [31:0] early_rdata);
    logic done;
    rdata = '0; resp = 2'b11; stalls = 0; first_resp = 2'b11; early_rdata = '0; done = 1'b0;
    hsel0 = !use2; hsel2 = use2;
    haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
    @(posedge hclk); #1;
    hsel0 = 1'b0; hsel2 = 1'b0; htrans = 2'b00; hwdata = wdata;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge hclk);
      if (i == 0) first_resp = use2 ? rsp2 : rsp0;
      if (use2 ? ro2 : ro0) begin
        rdata = use2 ? rd2 : rd0;
        resp  = use2 ? rsp2 : rsp0;
        done  = 1'b1;
      end else begin
        stalls++;
        early_rdata = early_rdata | (use2 ? rd2 : rd0);
      end
    end
    if (!done) stalls = -1;
    @(posedge hclk); #1;
  endtask

  logic [31:0] rd, er;
  logic [1:0]  rs, fr;
  int          st;

  task automatic test_reset();
    @(negedge hclk);
    n_vec++; if (ro0 !== 1'b1)   begin n_err++; $display("FAIL rst_ready0: got %b expected 1", ro0); end
    n_vec++; if (rsp0 !== 2'b00) begin n_err++; $display("FAIL rst_resp0: got %b expected 00", rsp0); end
    n_vec++; if (rd0 !== 32'h0)  begin n_err++; $display("FAIL rst_rdata0: got %h expected 00000000", rd0); end
    n_vec++; if (ro2 !== 1'b1)   begin n_err++; $display("FAIL rst_ready2: got %b expected 1", ro2); end
    n_vec++; if (rsp2 !== 2'b00) begin n_err++; $display("FAIL rst_resp2: got %b expected 00", rsp2); end
    n_vec++; if (rd2 !== 32'h0)  begin n_err++; $display("FAIL rst_rdata2: got %h expected 00000000", rd2); end
  endtask

  task automatic test_write_read();
    do_xfer(1'b0, 32'h10, 1'b1, 3'b010, 32'hDEADBEEF, rd, rs, st, fr, er);
    n_vec++; if (st !== 0)     begin n_err++; $display("FAIL wr_stalls: got %0d expected 0", st); end
    n_vec++; if (rs !== 2'b00) begin n_err++; $display("FAIL wr_resp: got %b expected 00", rs); end
    do_xfer(1'b0, 32'h10, 1'b0, 3'b010, 32'h0, rd, rs, st, fr, er);
    n_vec++; if (st !== 0)             begin n_err++; $display("FAIL rd_stalls: got %0d expected 0", st); end
    n_vec++; if (rd !== 32'hDEADBEEF)  begin n_err++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    n_vec++; if (rs !== 2'b00)         begin n_err++; $display("FAIL rd_resp: got %b expected 00", rs); end
  endtask

  task automatic test_wait_states();
    do_xfer(1'b1, 32'h40, 1'b1, 3'b010, 32'h12345678, rd, rs, st, fr, er);
    n_vec++; if (st !== 2) begin n_err++; $display("FAIL ws_wr_stalls: got %0d expected 2", st); end
    do_xfer(1'b1, 32'h40, 1'b0, 3'b010, 32'h0, rd, rs, st, fr, er);
    n_vec++; if (st !== 2)            begin n_err++; $display("FAIL ws_rd_stalls: got %0d expected 2", st); end
    n_vec++; if (er !== 32'h0)        begin n_err++; $display("FAIL ws_early_rdata: got %h expected 00000000", er); end
    n_vec++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL ws_rd_data: got %h expected 12345678", rd); end
    n_vec++; if (rs !== 2'b00)        begin n_err++; $display("FAIL ws_rd_resp: got %b expected 00", rs); end
  endtask

  task automatic test_byte_lanes();
    do_xfer(1'b0, 32'h10, 1'b1, 3'b010, 32'h11223344, rd, rs, st, fr, er);
    do_xfer(1'b0, 32'h13, 1'b1, 3'b000, 32'hAA000000, rd, rs, st, fr, er);
    do_xfer(1'b0, 32'h10, 1'b0, 3'b010, 32'h0, rd, rs, st, fr, er);
    n_vec++; if (rd !== 32'hAA223344) begin n_err++; $display("FAIL byte3: got %h expected aa223344", rd); end
    do_xfer(1'b0, 32'h14, 1'b1, 3'b010, 32'h01020304, rd, rs, st, fr, er);
    do_xfer(1'b0, 32'h16, 1'b1, 3'b001, 32'hBEEF0000, rd, rs, st, fr, er);
    do_xfer(1'b0, 32'h14, 1'b0, 3'b010, 32'h0, rd, rs, st, fr, er);
    n_vec++; if (rd !== 32'hBEEF0304) begin n_err++; $display("FAIL half_hi: got %h expected beef0304", rd); end
    do_xfer(1'b0, 32'h14, 1'b1, 3'b000, 32'h000000FF, rd, rs, st, fr, er);
    do_xfer(1'b0, 32'h14, 1'b0, 3'b010, 32'h0, rd, rs, st, fr, er);
    n_vec++; if (rd !== 32'hBEEF03FF) begin n_err++; $display("FAIL byte0: got %h expected beef03ff", rd); end
  endtask

  task automatic test_out_of_range();
    do_xfer(1'b0, 32'h0, 1'b1, 3'b010, 32'h0BADC0DE, rd, rs, st, fr, er);
    do_xfer(1'b0, 32'h1000, 1'b1, 3'b010, 32'hFFFFFFFF, rd, rs, st, fr, er);
    n_vec++; if (st !== 1)     begin n_err++; $display("FAIL oor_stalls: got %0d expected 1", st); end
    n_vec++; if (fr !== 2'b01) begin n_err++; $display("FAIL oor_resp1: got %b expected 01", fr); end
    n_vec++; if (rs !== 2'b01) begin n_err++; $display("FAIL oor_resp2: got %b expected 01", rs); end
    do_xfer(1'b0, 32'h1000, 1'b0, 3'b010, 32'h0, rd, rs, st, fr, er);
    n_vec++; if ((rd | er) !== 32'h0) begin n_err++; $display("FAIL oor_rdata: got %h expected 00000000", rd | er); end
    do_xfer(1'b0, 32'h0, 1'b1, 3'b011, 32'hFFFFFFFF, rd, rs, st, fr, er);
    n_vec++; if (rs !== 2'b01) begin n_err++; $display("FAIL bad_size_resp: got %b expected 01", rs); end
    do_xfer(1'b0, 32'h0, 1'b0, 3'b010, 32'h0, rd, rs, st, fr, er);
    n_vec++; if (rd !== 32'h0BADC0DE) begin n_err++; $display("FAIL oor_mem: got %h expected 0badc0de", rd); end
  endtask

  task automatic test_misaligned();
    hsel0 = 1'b1; haddr = 32'h01; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b001; hwdata = 32'hFFFFFFFF;
    @(posedge hclk); #1;
    hsel0 = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    n_vec++; if (ro0 !== 1'b0)   begin n_err++; $display("FAIL mis_ready1: got %b expected 0", ro0); end
    n_vec++; if (rsp0 !== 2'b01) begin n_err++; $display("FAIL mis_resp1: got %b expected 01", rsp0); end
    n_vec++; if (rd0 !== 32'h0)  begin n_err++; $display("FAIL mis_rdata1: got %h expected 00000000", rd0); end
    @(posedge hclk); #1;
    hsel0 = 1'b1; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010;
    @(negedge hclk);
    n_vec++; if (ro0 !== 1'b1)   begin n_err++; $display("FAIL mis_ready2: got %b expected 1", ro0); end
    n_vec++; if (rsp0 !== 2'b01) begin n_err++; $display("FAIL mis_resp2: got %b expected 01", rsp0); end
    @(posedge hclk); #1;
    hsel0 = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    n_vec++; if (rsp0 !== 2'b00)       begin n_err++; $display("FAIL mis_next_resp: got %b expected 00", rsp0); end
    n_vec++; if (rd0 !== 32'hAA223344) begin n_err++; $display("FAIL mis_next_data: got %h expected aa223344", rd0); end
    @(posedge hclk); #1;
    do_xfer(1'b0, 32'h0, 1'b0, 3'b010, 32'h0, rd, rs, st, fr, er);
    n_vec++; if (rd !== 32'h0BADC0DE) begin n_err++; $display("FAIL mis_mem: got %h expected 0badc0de", rd); end
  endtask

  task automatic test_back_to_back();
    hsel0 = 1'b1; haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    hwdata = 32'h5A5AA5A5; haddr = 32'h20; hwrite = 1'b0;
    @(negedge hclk);
    n_vec++; if (ro0 !== 1'b1) begin n_err++; $display("FAIL b2b_wr_ready: got %b expected 1", ro0); end
    @(posedge hclk); #1;
    hsel0 = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    n_vec++; if (rd0 !== 32'h5A5AA5A5) begin n_err++; $display("FAIL b2b_raw: got %h expected 5a5aa5a5", rd0); end
    @(posedge hclk); #1;
  endtask

  task automatic test_reset_mid_transfer();
    hsel2 = 1'b1; haddr = 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    hsel2 = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
    @(negedge hclk);
    n_vec++; if (ro2 !== 1'b0) begin n_err++; $display("FAIL mid_wait: got %b expected 0", ro2); end
    #2 hresetn = 1'b0;
    #1;
    n_vec++; if (ro2 !== 1'b1)   begin n_err++; $display("FAIL mid_rst_ready: got %b expected 1", ro2); end
    n_vec++; if (rsp2 !== 2'b00) begin n_err++; $display("FAIL mid_rst_resp: got %b expected 00", rsp2); end
    n_vec++; if (rd2 !== 32'h0)  begin n_err++; $display("FAIL mid_rst_rdata: got %h expected 00000000", rd2); end
    @(posedge hclk);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    do_xfer(1'b1, 32'h40, 1'b0, 3'b010, 32'h0, rd, rs, st, fr, er);
    n_vec++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL mid_mem: got %h expected 12345678", rd); end
    n_vec++; if (st !== 2)            begin n_err++; $display("FAIL mid_post_stalls: got %0d expected 2", st); end
  endtask

  initial begin
    hresetn = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011; hmastlock = 1'b0; hwdata = '0;
    repeat (2) @(posedge hclk);
    test_reset();
    @(posedge hclk); #1;
    hresetn = 1'b1;
    test_write_read();
    test_wait_states();
    test_byte_lanes();
    test_out_of_range();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
